// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the multiplier sharing controller.
package mult_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int ID_W      = $clog2(NREQ_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Round-robin pick: first asserted request at or above ptr, wrapping mod NREQ.
module rr_arbiter4 #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  // NREQ is a power of two, so the IDW-bit add wraps for free.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr + IDW'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one shift-add multiplier among NREQ requesters: round-robin accept,
// operand issue, watchdog-supervised wait, and a held response handshake.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = 31
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    rsp_err,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_product,
  output logic                    mul_abort
);

  localparam int IDW = (NREQ == NREQ_DEF) ? ID_W : $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   gidx;
  logic [NREQ-1:0]  grant;
  logic             any_req;
  logic [WDW-1:0]   wdog_q;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             op_zero, wd_expire;

  rr_arbiter4 #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx),
    .any   (any_req)
  );

  assign a_sel     = req_a[int'(gidx)*WIDTH +: WIDTH];
  assign b_sel     = req_b[int'(gidx)*WIDTH +: WIDTH];
  assign op_zero   = (mul_a == '0) || (mul_b == '0);
  // A done arriving in the last allowed WAIT cycle still wins over the abort.
  assign wd_expire = (wdog_q == WDW'(TIMEOUT - 1)) && !mul_done;
  // Gated by reset so no strobe escapes while the block is held in reset.
  assign req_ready = (state_q == IDLE && reset) ? grant : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (any_req) state_d = ISSUE;
      ISSUE: state_d = op_zero ? RESP : WAIT;
      WAIT:  if (mul_done || wd_expire) state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mul_start is registered at accept so it is high exactly in the ISSUE cycle;
  // mul_abort likewise lands in the first RESP cycle, alongside rsp_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      wdog_q      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_abort   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_start <= 1'b0;
      mul_abort <= 1'b0;
      case (state_q)
        IDLE: if (any_req) begin
          mul_a     <= a_sel;
          mul_b     <= b_sel;
          rsp_id    <= gidx;
          mul_start <= (a_sel != '0) && (b_sel != '0);
        end
        ISSUE: begin
          wdog_q <= '0;
          if (op_zero) begin
            rsp_product <= '0;
            rsp_err     <= 1'b0;
            rsp_valid   <= 1'b1;
          end
        end
        WAIT: begin
          if (mul_done) begin
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
            rsp_valid   <= 1'b1;
          end else if (wd_expire) begin
            mul_abort   <= 1'b1;
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            rsp_valid   <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ptr_q     <= rsp_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier stand-in plus a transaction-level
// reference (round-robin pointer, a*b, latency from the operation rules).
module tb_mult_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 31;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_product;
  logic        rsp_err;
  logic        mul_start, mul_done, mul_abort;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_product;

  mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product), .mul_abort(mul_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  int ref_ptr = 0;
  int next_free = 0;
  int m_lat = -1;
  bit stray = 1'b0;
  logic [7:0] ra [4];
  logic [7:0] rb [4];

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = ra[i];
      req_b[i*8 +: 8] = rb[i];
    end
  endtask

  // Multiplier stand-in: done pulse m_lat cycles into WAIT (-1 = never).
  initial begin
    int rem;
    bit act;
    logic [15:0] prod;
    act = 0; rem = 0; prod = '0;
    mul_done = 1'b0; mul_product = '0;
    forever begin
      @(negedge clk);
      if (!reset) act = 0;
      else begin
        if (mul_abort) act = 0;
        if (mul_start && m_lat >= 0) begin
          act = 1; rem = m_lat; prod = 16'(mul_a) * 16'(mul_b);
        end
      end
      @(posedge clk); #1;
      mul_done = 1'b0;
      mul_product = 16'($urandom);
      if (stray) begin
        mul_done = 1'b1; stray = 0;
      end else if (act && reset) begin
        if (rem == 0) begin mul_done = 1'b1; mul_product = prod; act = 0; end
        else rem--;
      end
    end
  end

  // One complete transaction; called in the phase just after a rising edge.
  task automatic run_one(input logic [3:0] vmask, input int lat, input int hold,
                         input bit do_stray, input bit keep_valid, input string tag,
                         output int t_acc);
    int g, t_rsp, nstart, nabort, bad, exp_t;
    logic [7:0] ea, eb;
    logic [15:0] exp_p;
    bit zero, tmo;
    g = -1;
    for (int i = 0; i < 4; i++)
      if (g < 0 && vmask[(ref_ptr + i) % 4]) g = (ref_ptr + i) % 4;
    ea = ra[g]; eb = rb[g];
    zero  = (ea == 0) || (eb == 0);
    tmo   = !zero && (lat < 0 || lat >= TIMEOUT);
    exp_p = (zero || tmo) ? 16'd0 : 16'(int'(ea) * int'(eb));
    exp_t = zero ? 2 : (tmo ? 2 + TIMEOUT : 3 + lat);
    m_lat = lat;
    drive_ops();
    req_valid = vmask;
    t_acc = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin t_acc = cyc; break; end
    end
    checks++;
    if (t_acc < 0 || req_ready !== 4'(1 << g)) begin
      errors++;
      $display("FAIL %s grant: got %b want %b", tag, req_ready, 4'(1 << g));
      req_valid = '0; @(posedge clk); #1;
      return;
    end
    nstart = 0; nabort = 0; bad = 0; t_rsp = -1;
    for (int k = 0; k < TIMEOUT + 10; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        if (!keep_valid) req_valid = '0;
        for (int i = 0; i < 4; i++) begin
          ra[i] = 8'($urandom_range(0, 255)); rb[i] = 8'($urandom_range(0, 255));
        end
        drive_ops();
      end
      @(negedge clk);
      if (req_ready !== 4'b0) bad++;
      if (mul_start) begin
        nstart++;
        if (cyc != t_acc + 1 || mul_a !== ea || mul_b !== eb) bad++;
      end
      if (mul_abort) nabort++;
      if (rsp_valid) begin t_rsp = cyc; break; end
    end
    checks++;
    if (t_rsp - t_acc != exp_t) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", tag, t_rsp - t_acc, exp_t);
    end
    checks++;
    if (rsp_id !== 2'(g)) begin
      errors++; $display("FAIL %s rsp_id: got %0d want %0d", tag, rsp_id, g);
    end
    checks++;
    if (rsp_product !== exp_p) begin
      errors++; $display("FAIL %s product: got %0d want %0d", tag, rsp_product, exp_p);
    end
    checks++;
    if (rsp_err !== tmo) begin
      errors++; $display("FAIL %s rsp_err: got %b want %b", tag, rsp_err, tmo);
    end
    checks++;
    if (nstart != (zero ? 0 : 1)) begin
      errors++; $display("FAIL %s mul_start count: got %0d want %0d", tag, nstart, zero ? 0 : 1);
    end
    checks++;
    if (nabort != (tmo ? 1 : 0)) begin
      errors++; $display("FAIL %s mul_abort count: got %0d want %0d", tag, nabort, tmo ? 1 : 0);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s issue window: got %0d bad cycles want 0", tag, bad);
    end
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h == 0 && do_stray) stray = 1;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_product !== exp_p ||
          rsp_err !== tmo || req_ready !== 4'b0 || mul_abort !== 1'b0 || mul_start !== 1'b0)
        bad++;
    end
    if (hold > 0) begin
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL %s hold stable: got %0d bad cycles want 0", tag, bad);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    ref_ptr = (g + 1) % 4;
    next_free = cyc;
    checks++;
    if (rsp_valid !== 1'b0 || mul_abort !== 1'b0) begin
      errors++; $display("FAIL %s after handshake: got valid=%b abort=%b want 0 0", tag, rsp_valid, mul_abort);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    #2 reset = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || mul_start !== 1'b0 || mul_abort !== 1'b0) begin
      errors++; $display("FAIL reset strobes: got rdy=%b v=%b s=%b ab=%b want 0", req_ready, rsp_valid, mul_start, mul_abort);
    end
    checks++;
    if (rsp_id !== 2'b0 || rsp_product !== 16'b0 || rsp_err !== 1'b0 || mul_a !== 8'b0 || mul_b !== 8'b0) begin
      errors++; $display("FAIL reset data: got id=%0d p=%0d e=%b a=%0d b=%0d want 0", rsp_id, rsp_product, rsp_err, mul_a, mul_b);
    end
    req_valid = '0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    ref_ptr = 0;
  endtask

  task automatic test_round_robin();
    int t;
    for (int i = 0; i < 4; i++) begin ra[i] = 8'(i + 3); rb[i] = 8'(i + 5); end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (ref_ptr != n) begin errors++; $display("FAIL rr ptr: got %0d want %0d", ref_ptr, n); end
      run_one(4'hF, 2, 0, 0, 1, "rr_all", t);
    end
    ra[0] = 8'd6; rb[0] = 8'd7; ra[3] = 8'd8; rb[3] = 8'd9;
    run_one(4'b1001, 1, 0, 0, 0, "rr_wrap", t);
  endtask

  task automatic test_single();
    int t;
    ra[2] = 8'd13; rb[2] = 8'd11;
    run_one(4'b0100, 9, 0, 0, 0, "single", t);
  endtask

  task automatic test_zero_operand();
    int t;
    ra[0] = 8'd0; rb[0] = 8'd200;
    run_one(4'b0001, 3, 0, 0, 0, "zero_op", t);
  endtask

  task automatic test_timeout();
    int t;
    ra[1] = 8'd9; rb[1] = 8'd9;
    run_one(4'b0010, -1, 0, 0, 0, "timeout", t);
    ra[3] = 8'd17; rb[3] = 8'd15;
    run_one(4'b1000, 2, 0, 0, 0, "post_timeout", t);
  endtask

  task automatic test_stall();
    int t;
    ra[1] = 8'd200; rb[1] = 8'd3;
    run_one(4'b0010, 4, 5, 1, 0, "stall", t);
    ra[2] = 8'd255; rb[2] = 8'd255;
    run_one(4'b0100, TIMEOUT - 1, 0, 0, 0, "coincide", t);
  endtask

  task automatic test_back_to_back();
    int t, nf;
    for (int i = 0; i < 4; i++) begin ra[i] = 8'(i + 21); rb[i] = 8'(i + 2); end
    run_one(4'hF, 1, 0, 0, 1, "b2b_first", t);
    nf = next_free;
    run_one(4'hF, 1, 0, 0, 1, "b2b_second", t);
    checks++;
    if (t != nf) begin errors++; $display("FAIL b2b accept cycle: got %0d want %0d", t, nf); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int bad, t;
    ra[2] = 8'd5; rb[2] = 8'd7; drive_ops();
    m_lat = -1;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL midrst accept: got %b want 0100", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || mul_start !== 1'b0 || mul_abort !== 1'b0 ||
        mul_a !== 8'b0 || mul_b !== 8'b0 || rsp_id !== 2'b0 || rsp_product !== 16'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL midrst outputs: got a=%0d b=%0d v=%b ab=%b want all 0", mul_a, mul_b, rsp_valid, mul_abort);
    end
    @(negedge clk) reset = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mul_abort !== 1'b0 || mul_start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst quiet: got %0d bad cycles want 0", bad); end
    @(posedge clk); #1;
    ref_ptr = 0;
    ra[0] = 8'd4; rb[0] = 8'd4;
    run_one(4'hF, 3, 0, 0, 0, "midrst_ptr0", t);
  endtask

  task automatic test_random();
    int t, r, lat, hold;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) begin
        ra[i] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        rb[i] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      r = $urandom_range(0, 9);
      lat = (r == 0) ? -1 : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 12);
      hold = $urandom_range(0, 3);
      run_one(4'($urandom_range(1, 15)), lat, hold, hold >= 2 && $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, "random", t);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_operand();
    test_timeout();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete in time");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Sequencing and sharing controller for the 8x8 shift-add multiplier. Accepts multiply requests from up to NREQ requesters, grants one at a time by round-robin, issues the operands to the single shared multiplier, and supervises completion with a watchdog. Returns each product with its requester ID over a response handshake. Sits between the client blocks and the multiplier datapath/control unit.

## Interface
- NREQ, 4, number of requesters (power of 2, ≥2)
- WIDTH, 8, operand width; product is 2*WIDTH
- TIMEOUT, 31, max cycles spent in WAIT before abort (≥1)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot accept strobe
- req_a  in  NREQ*WIDTH  multiplicands, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  multipliers, same packing
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  log2(NREQ)  requester index of response
- rsp_product  out  2*WIDTH  product
- rsp_err  out  1  1 = watchdog abort, product forced 0
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_a, mul_b  out  WIDTH  operands, stable from ISSUE until leaving WAIT
- mul_done  in  1  multiplier completion pulse
- mul_product  in  2*WIDTH  valid in the mul_done cycle
- mul_abort  out  1  one-cycle pulse that clears the multiplier

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, pick first set bit scanning from ptr upward (mod NREQ); req_ready[g]=1 that cycle only; capture req_a/req_b of g and id g; -> ISSUE. No req_valid: stay.
- ISSUE: if captured a==0 or b==0: product=0, err=0, no mul_start, -> RESP. Else mul_start=1, clear watchdog, -> WAIT.
- WAIT: mul_done=1 -> capture mul_product, err=0, -> RESP. Else watchdog++; watchdog reaching TIMEOUT -> mul_abort=1, product=0, err=1, -> RESP. mul_done in same cycle as timeout: done wins, no abort.
- RESP: rsp_valid=1, rsp_id/product/err held stable until rsp_ready; on handshake ptr=(g+1) mod NREQ, -> IDLE.
- req_ready all-zero outside IDLE; mul_done outside WAIT ignored.
- Product width: 2*WIDTH, no truncation; max 255*255=65025.

## Timing
- Reset (async assert, sync release): state IDLE, ptr 0, watchdog 0, all outputs 0 (req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_a, mul_b, mul_abort).
- Reset mid-operation: in-flight request dropped, no response, no mul_abort pulse (multiplier shares reset).
- Accept at cycle T; mul_start at T+1; WAIT from T+2; mul_done at T+2+k -> rsp_valid at T+3+k.
- Zero operand: rsp_valid at T+2.
- Timeout: mul_abort and transition at the TIMEOUT-th WAIT cycle; rsp_valid next cycle.
- Back-to-back: next accept earliest the cycle after the rsp handshake.
- All outputs registered except req_ready (decoded from state and grant).

## Structure
- Package mult_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), NREQ/WIDTH defaults, ID width constant.
- Sub-module rr_arbiter4: round-robin grant from req vector and ptr, outputs one-hot grant and encoded index.
- Top holds FSM, operand/product/id registers, watchdog counter.

## Test plan
- Single request id 2, a=13, b=11; model returns mul_done after 9 cycles with 143 -> one mul_start with mul_a=13, mul_b=11; rsp id=2, product=143, err=0 at accept+12.
- All four req_valid held from reset -> grants 0,1,2,3; then only 0 and 3 valid -> grant 0 (ptr wrapped from 3).
- a=0, b=200 -> no mul_start; rsp product=0, err=0 at accept+2.
- mul_done never asserted -> mul_abort single pulse at WAIT cycle 31; rsp err=1, product=0; next request proceeds normally.
- rsp_ready low 5 cycles, stray mul_done during RESP -> rsp fields stable, req_ready stays 0, stray done ignored; mul_done coincident with timeout -> err=0, no abort.
- reset asserted in WAIT -> all outputs 0 immediately, IDLE, ptr 0; no response emitted.
